// File: rtl/pdp8_panel_pkg.sv
// Shared constants for the PDP-8 front-panel switch conditioner:
// channel indices, channel count and default timing parameters.
package pdp8_panel_pkg;

  localparam int unsigned NUM_CH = 4;

  localparam int unsigned CH_RESET = 0;
  localparam int unsigned CH_CLEAR = 1;
  localparam int unsigned CH_RUN   = 2;
  localparam int unsigned CH_HALT  = 3;

  // 20 ms at 12 MHz SYSCLK
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 240000;
  localparam int unsigned RESET_STRETCH_DEF   = 16;

  typedef logic [NUM_CH-1:0] ch_vec_t;

endpackage : pdp8_panel_pkg

// File: rtl/panel_switches_if.sv
// Pin-side and CPU-side signals of the front-panel switch conditioner.
// The master drives the raw buttons; the slave (the conditioner) drives the clean switches.
interface panel_switches_if;

  logic pin_RESET;
  logic pin_CLEAR;
  logic pin_RUN;
  logic pin_HALT;

  logic sw_RESET;
  logic sw_CLEAR;
  logic sw_RUN;
  logic sw_HALT;

  modport master (
    output pin_RESET,
    output pin_CLEAR,
    output pin_RUN,
    output pin_HALT,
    input  sw_RESET,
    input  sw_CLEAR,
    input  sw_RUN,
    input  sw_HALT
  );

  modport slave (
    input  pin_RESET,
    input  pin_CLEAR,
    input  pin_RUN,
    input  pin_HALT,
    output sw_RESET,
    output sw_CLEAR,
    output sw_RUN,
    output sw_HALT
  );

endinterface : panel_switches_if

// File: rtl/panel_debounce.sv
// One panel channel: two-flop synchronizer, debounce counter, stable level
// and a one-cycle press strobe on a qualified 0->1 change.
module panel_debounce
  import pdp8_panel_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic stable_o,
  output logic press_o
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             press_q;
  logic             press_d;

  // Metastability guard for the asynchronous button pin.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
    end
  end

  // Any sample agreeing with stable_q drops the count back to zero.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        press_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign stable_o = stable_q;
  assign press_o  = press_q;

endmodule : panel_debounce

// File: rtl/panel_switches.sv
// Front-panel switch conditioner for the PDP-8 core: debounces RESET/CLEAR/RUN/HALT,
// stretches sw_RESET and arbitrates strobes. Define PANEL_INVERT_EN for active-low buttons.
module panel_switches
  import pdp8_panel_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned RESET_STRETCH   = RESET_STRETCH_DEF
) (
  input  logic             SYSCLK,
  input  logic             RESET,
  panel_switches_if.slave  pnl
);

  localparam int unsigned     RST_W    = $clog2(RESET_STRETCH + 1);
  localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RESET_STRETCH);

  ch_vec_t          pin_raw;
  ch_vec_t          pin_cond;
  ch_vec_t          stable;
  ch_vec_t          press;
  logic [RST_W-1:0] rst_cnt_q;
  logic [RST_W-1:0] rst_cnt_d;
  logic             sw_reset_c;
  logic             unused_ch_status;

  assign pin_raw[CH_RESET] = pnl.pin_RESET;
  assign pin_raw[CH_CLEAR] = pnl.pin_CLEAR;
  assign pin_raw[CH_RUN]   = pnl.pin_RUN;
  assign pin_raw[CH_HALT]  = pnl.pin_HALT;

  // Synchronizers still clear to 0, so a released (high) active-low pin never strobes.
`ifdef PANEL_INVERT_EN
  assign pin_cond = ~pin_raw;
`else
  assign pin_cond = pin_raw;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    panel_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i    (SYSCLK),
      .rst_i    (RESET),
      .pin_i    (pin_cond[g]),
      .stable_o (stable[g]),
      .press_o  (press[g])
    );
  end

  // Only the RESET channel's level and the other channels' strobes are consumed.
  assign unused_ch_status = ^{stable[CH_HALT], stable[CH_RUN], stable[CH_CLEAR], press[CH_RESET]};

  // Reset stretcher: reload while the button is held, then count down and hold at 0.
  always_comb begin
    rst_cnt_d = rst_cnt_q;
    if (stable[CH_RESET]) begin
      rst_cnt_d = RST_LOAD;
    end else if (rst_cnt_q != '0) begin
      rst_cnt_d = rst_cnt_q - RST_W'(1);
    end
  end

  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      rst_cnt_q <= RST_LOAD;
    end else begin
      rst_cnt_q <= rst_cnt_d;
    end
  end

  assign sw_reset_c = stable[CH_RESET] | (rst_cnt_q != '0);

  // HALT wins over a coincident RUN; everything is masked while reset is active.
  assign pnl.sw_RESET = sw_reset_c;
  assign pnl.sw_CLEAR = press[CH_CLEAR] & ~sw_reset_c;
  assign pnl.sw_HALT  = press[CH_HALT]  & ~sw_reset_c;
  assign pnl.sw_RUN   = press[CH_RUN]   & ~press[CH_HALT] & ~sw_reset_c;

endmodule : panel_switches

// File: tb/tb_panel_switches.sv
// Directed self-checking bench for panel_switches with DEBOUNCE_CYCLES=8, RESET_STRETCH=4.
module tb_panel_switches;

  logic SYSCLK;
  logic RESET;
  int   checks   = 0;
  int   failures = 0;
  int   n_clear  = 0;
  int   n_run    = 0;
  int   n_halt   = 0;

  panel_switches_if pnl ();

  panel_switches #(
    .DEBOUNCE_CYCLES (8),
    .RESET_STRETCH   (4)
  ) dut (
    .SYSCLK (SYSCLK),
    .RESET  (RESET),
    .pnl    (pnl.slave)
  );

  initial SYSCLK = 1'b0;
  always #5 SYSCLK = ~SYSCLK;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One rising edge, then sample 1 ns later and tally strobes.
  task automatic tick();
    @(posedge SYSCLK);
    #1;
    if (pnl.sw_CLEAR === 1'b1) n_clear++;
    if (pnl.sw_RUN   === 1'b1) n_run++;
    if (pnl.sw_HALT  === 1'b1) n_halt++;
  endtask

  task automatic clear_counts();
    n_clear = 0;
    n_run   = 0;
    n_halt  = 0;
  endtask

  initial begin
    RESET         = 1'b1;
    pnl.pin_RESET = 1'b0;
    pnl.pin_CLEAR = 1'b0;
    pnl.pin_RUN   = 1'b0;
    pnl.pin_HALT  = 1'b0;
    repeat (3) tick();

    // Reset state
    check_bit("rst_sw_RESET", pnl.sw_RESET, 1'b1);
    check_bit("rst_sw_CLEAR", pnl.sw_CLEAR, 1'b0);
    check_bit("rst_sw_RUN",   pnl.sw_RUN,   1'b0);
    check_bit("rst_sw_HALT",  pnl.sw_HALT,  1'b0);

    // 1: stretch after block reset release
    clear_counts();
    RESET = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check_bit($sformatf("t1_sw_RESET_e%0d", i), pnl.sw_RESET, (i < 4) ? 1'b1 : 1'b0);
    end
    check_int("t1_pulses", n_clear + n_run + n_halt, 0);

    // 2: held RUN gives one pulse after edge 10, none on release
    clear_counts();
    pnl.pin_RUN = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i >= 9 && i <= 11)
        check_bit($sformatf("t2_sw_RUN_e%0d", i), pnl.sw_RUN, (i == 10) ? 1'b1 : 1'b0);
    end
    check_int("t2_run_pulses", n_run, 1);
    clear_counts();
    pnl.pin_RUN = 1'b0;
    repeat (20) tick();
    check_int("t2_release_pulses", n_clear + n_run + n_halt, 0);

    // 3: CLEAR toggling every 3 cycles never qualifies
    clear_counts();
    for (int i = 0; i < 30; i++) begin
      pnl.pin_CLEAR = (((i / 3) % 2) == 0) ? 1'b1 : 1'b0;
      tick();
    end
    pnl.pin_CLEAR = 1'b0;
    repeat (20) tick();
    check_int("t3_clear_pulses", n_clear, 0);

    // 4: coincident RUN and HALT -> HALT only
    clear_counts();
    pnl.pin_RUN  = 1'b1;
    pnl.pin_HALT = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i == 10) check_bit("t4_sw_HALT_e10", pnl.sw_HALT, 1'b1);
    end
    check_int("t4_halt_pulses", n_halt, 1);
    check_int("t4_run_pulses",  n_run,  0);
    pnl.pin_RUN  = 1'b0;
    pnl.pin_HALT = 1'b0;
    repeat (20) tick();

    // 5: RESET button with RUN pressed alongside
    clear_counts();
    pnl.pin_RESET = 1'b1;
    pnl.pin_RUN   = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check_bit($sformatf("t5_press_sw_RESET_e%0d", i), pnl.sw_RESET, (i >= 10) ? 1'b1 : 1'b0);
    end
    pnl.pin_RESET = 1'b0;
    pnl.pin_RUN   = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      tick();
      check_bit($sformatf("t5_rel_sw_RESET_e%0d", j), pnl.sw_RESET, (j <= 13) ? 1'b1 : 1'b0);
    end
    check_int("t5_run_pulses", n_run, 0);

    // 6: block reset mid-debounce forces a fresh qualification
    clear_counts();
    pnl.pin_HALT = 1'b1;
    repeat (5) tick();
    RESET = 1'b1;
    repeat (2) tick();
    check_bit("t6_in_reset_sw_RESET", pnl.sw_RESET, 1'b1);
    RESET = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check_bit($sformatf("t6_sw_HALT_e%0d", k), pnl.sw_HALT, (k == 10) ? 1'b1 : 1'b0);
    end
    check_int("t6_halt_pulses", n_halt, 1);
    check_bit("t6_sw_RESET_end", pnl.sw_RESET, 1'b0);
    pnl.pin_HALT = 1'b0;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_panel_switches
